// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op encoding, latencies and reservation-slot type for the FPU issue scheduler.
package fpu_pkg;

    typedef enum logic [2:0] {
        FADD  = 3'd0,
        FMUL  = 3'd1,
        FDIV  = 3'd2,
        FSQRT = 3'd3,
        FHALF = 3'd4
    } fpu_op_t;

    localparam int LAT_FADD  = 2;
    localparam int LAT_FMUL  = 2;
    localparam int LAT_FDIV  = 8;
    localparam int LAT_FSQRT = 8;
    localparam int LAT_FHALF = 1;
    localparam int MAXLAT    = 15;
    localparam int TAGW      = 5;

    typedef struct packed {
        logic            valid;
        logic [2:0]      op;
        logic [TAGW-1:0] tag;
    } resv_t;

    function automatic int op_lat(input fpu_op_t op);
        return op == FADD ? LAT_FADD :
               op == FMUL ? LAT_FMUL :
               op == FDIV ? LAT_FDIV :
               op == FSQRT ? LAT_FSQRT : LAT_FHALF;
    endfunction

    function automatic logic is_iter(input fpu_op_t op);
        return op == FDIV || op == FSQRT;
    endfunction

endpackage

// File: rtl/fpu_resv_line.sv
// fpu_resv_line: writeback reservation shift line; slot 0 is the op completing this cycle.
module fpu_resv_line
    import fpu_pkg::*;
#(
    parameter int DEPTH = MAXLAT,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [LW-1:0] i_wr_idx,
    input  resv_t         i_wr_data,
    input  logic [LW-1:0] i_q_idx,
    output logic          o_q_valid,
    output resv_t         o_head,
    output logic          o_any
);

    resv_t          r_slot  [DEPTH];
    resv_t          w_shift [DEPTH];
    logic [DEPTH:0] w_vld;

    // the extra top bit stands for slot[DEPTH], which is never occupied
    assign w_vld[DEPTH] = 1'b0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        if (k == DEPTH - 1) begin : g_top
            assign w_shift[k] = '0;
        end else begin : g_mid
            assign w_shift[k] = r_slot[k+1];
        end
        assign w_vld[k] = r_slot[k].valid;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                r_slot[k] <= i_flush ? '0 :
                             (i_wr_en && i_wr_idx == LW'(k)) ? i_wr_data : w_shift[k];
        end
    end

    assign o_q_valid = w_vld[i_q_idx];
    assign o_head    = r_slot[0];
    assign o_any     = |w_vld[DEPTH-1:0];

endmodule

// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: issues one FP op per cycle, reserving a unique writeback cycle per op
// and serialising the shared divide/sqrt unit.
module fpu_issue_sched
    import fpu_pkg::*;
#(
    parameter int P_LAT_FADD  = LAT_FADD,
    parameter int P_LAT_FMUL  = LAT_FMUL,
    parameter int P_LAT_FDIV  = LAT_FDIV,
    parameter int P_LAT_FSQRT = LAT_FSQRT,
    parameter int P_LAT_FHALF = LAT_FHALF,
    parameter int P_MAXLAT    = MAXLAT
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_req_valid,
    input  logic [2:0]      i_req_op,
    input  logic [TAGW-1:0] i_req_tag,
    output logic            o_req_ready,
    input  logic            i_flush,
    output logic            o_issue_valid,
    output logic [2:0]      o_issue_op,
    output logic            o_wb_valid,
    output logic [2:0]      o_wb_op,
    output logic [TAGW-1:0] o_wb_tag,
    output logic            o_illegal,
    output logic            o_busy
);

    localparam int LW      = $clog2(P_MAXLAT + 1);
    localparam int DIV_LAT = P_LAT_FDIV > P_LAT_FSQRT ? P_LAT_FDIV : P_LAT_FSQRT;

    logic [LW-1:0] r_div_cnt;
    logic          r_illegal;
    logic [LW-1:0] w_lat;
    logic          w_legal;
    logic          w_iter;
    logic          w_slot_busy;
    logic          w_conflict;
    logic          w_acc;
    logic          w_any;
    resv_t         w_head;

    assign w_legal = i_req_op <= 3'd4;
    assign w_iter  = w_legal && is_iter(fpu_op_t'(i_req_op));
    assign w_lat   = i_req_op == FADD  ? LW'(P_LAT_FADD)  :
                     i_req_op == FMUL  ? LW'(P_LAT_FMUL)  :
                     i_req_op == FDIV  ? LW'(P_LAT_FDIV)  :
                     i_req_op == FSQRT ? LW'(P_LAT_FSQRT) : LW'(P_LAT_FHALF);

    // an op landing in slot[L-1] collides with whatever currently sits in slot[L]
    assign w_conflict    = w_legal && (w_slot_busy || (w_iter && r_div_cnt != '0));
    assign o_req_ready   = !i_flush && !w_conflict;
    assign w_acc         = i_req_valid && o_req_ready;
    assign o_issue_valid = w_acc && w_legal;
    assign o_issue_op    = i_req_op;

    fpu_resv_line #(.DEPTH(P_MAXLAT), .LW(LW)) u_line (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_flush   (i_flush),
        .i_wr_en   (o_issue_valid),
        .i_wr_idx  (w_lat - LW'(1)),
        .i_wr_data ('{valid: 1'b1, op: i_req_op, tag: i_req_tag}),
        .i_q_idx   (w_lat),
        .o_q_valid (w_slot_busy),
        .o_head    (w_head),
        .o_any     (w_any)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_div_cnt <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_div_cnt <= i_flush ? '0 :
                         (o_issue_valid && w_iter) ? LW'(DIV_LAT - 1) :
                         r_div_cnt != '0 ? r_div_cnt - LW'(1) : r_div_cnt;
            r_illegal <= w_acc && !w_legal;
        end
    end

    assign o_wb_valid = w_head.valid;
    assign o_wb_op    = w_head.op;
    assign o_wb_tag   = w_head.tag;
    assign o_illegal  = r_illegal;
    assign o_busy     = w_any || r_div_cnt != '0;

endmodule
